md5_fifo: RTL and testbench
===========================

// Module: md5_fifo
//
// PURPOSE
// - Synchronous first-word-fall-through (FWFT) FIFO that holds the low 512 bits
//   (second MD5 block) of each 1024-bit hash request.
// - The pipelined MD5 engine writes one entry per accepted request. It pops the
//   entry when that request reaches the second-block stage, 66 cycles after the write.
// - The head entry must be visible on dout before the pop, so the consumer samples
//   dout on the same edge it asserts rd_en.
//
// PARAMETERS
// - DATA_W  512  width of one entry (bits)
// - DEPTH   128  number of entries; power of two, >= 67 (66 requests can be in flight)
// - ADDR_W  7    log2(DEPTH); pointer width
//
// PORTS
// - clk    in   1       single clock, rising edge
// - rst    in   1       reset, asynchronous, active-high
// - din    in   DATA_W  write data
// - wr_en  in   1       write request, sampled on the rising clk edge
// - rd_en  in   1       pop request, sampled on the rising clk edge
// - dout   out  DATA_W  head entry (FWFT)
// - full   out  1       1 when count == DEPTH
// - empty  out  1       1 when count == 0
//
// BEHAVIOUR
// - Reset (async, active-high):
//   - wr_ptr = rd_ptr = count = 0.
//   - empty = 1, full = 0.
//   - Storage contents are not cleared; dout is don't-care while empty.
// - Storage: DEPTH x DATA_W array. Pointers are ADDR_W bits and wrap naturally
//   from DEPTH-1 to 0. count is ADDR_W+1 bits, range 0..DEPTH.
// - Write accepted = wr_en & ~full:
//   - mem[wr_ptr] <= din, then wr_ptr increments.
// - Read accepted = rd_en & ~empty:
//   - rd_ptr increments, which exposes the next entry.
// - dout = mem[rd_ptr], combinational from the pointer.
//   - A written word appears on dout the cycle after the write if the FIFO was empty.
//   - dout stays stable until popped.
// - count update each edge:
//   - +1 on an accepted write only.
//   - -1 on an accepted read only.
//   - unchanged when both or neither are accepted.
// - full and empty are derived combinationally from count and change only on clock
//   edges or reset.
// - Boundary cases:
//   - Write while full: dropped, even if rd_en is also high. No state change from
//     the write; the read is still honoured.
//   - Read while empty: ignored. rd_ptr and count are unchanged.
//   - Write and read while empty: the write is accepted, the read is ignored (no
//     bypass). Result: count = 1.
//   - Write and read with 0 < count < DEPTH: both accepted, count unchanged, data
//     order preserved.
//   - Pointer wrap: strict FIFO order is preserved across wrap.
//   - Reset asserted mid-operation: the FIFO empties immediately and all pending
//     data is discarded.
// - Latency:
//   - write-to-visible (from empty): 1 cycle.
//   - pop-to-next-visible: 0 cycles after the edge.
// - No X propagation on flags after reset. Overflow and underflow are silent (no
//   error output).
//
// TESTING
// - Reset -> empty=1, full=0. Then rd_en=1 for 3 cycles -> empty stays 1 and
//   count stays 0.
// - Write 512'd10, then 512'd11 on back-to-back cycles -> the cycle after the first
//   write: empty=0, dout=10. After popping 10: dout=11. After popping 11: empty=1.
// - Pipeline pattern: wr_en each cycle for 66 cycles with din=i (i=0..65), rd_en
//   driven by wr_en delayed 66 cycles -> each pop returns i in order and count never
//   exceeds 66.
// - Fill to DEPTH with din=i -> full=1 after 128 writes. A 129th write (din=999)
//   is dropped: drain yields 0..127 only, then empty=1.
// - Full with wr_en=1, rd_en=1 -> read pops 0, write dropped, count=127, full=0.
// - Wrap and reset: 200 writes/reads interleaved at count 5 -> order kept across
//   pointer wrap. Assert rst mid-stream -> empty=1 immediately, full=0, and the next
//   write (din=512'hA5) is the next dout.

Source files
------------

// File: rtl/md5_fifo.sv
// First-word-fall-through FIFO holding the second 512-bit block of each MD5
// request until the engine's second-block stage pops it.
module md5_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;

    logic full_s;
    logic empty_s;
    logic wr_accept_s;
    logic rd_accept_s;

    assign full_s      = (count_q == CNT_FULL);
    assign empty_s     = (count_q == CNT_ZERO);
    // A full FIFO drops the write even when a pop frees a slot on the same edge.
    assign wr_accept_s = wr_en & ~full_s;
    assign rd_accept_s = rd_en & ~empty_s;

    assign full  = full_s;
    assign empty = empty_s;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_accept_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are intentionally left untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_md5_fifo.sv
// Randomized scoreboard bench for md5_fifo against a queue-based reference model.
module tb_md5_fifo;

    localparam int DATA_W = 512;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;

    md5_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    logic [DATA_W-1:0] model[$];
    logic [DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int max_occ  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // Monitor: every pop the DUT performs must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected no pop", dout);
            end else begin
                check("pop_data", dout, exp_q.pop_front());
            end
        end
    end

    // Checks visible state, applies one cycle of stimulus and advances the model.
    task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r);
        bit wa;
        bit ra;
        check("empty", {{(DATA_W-1){1'b0}}, empty}, {{(DATA_W-1){1'b0}}, model.size() == 0});
        check("full",  {{(DATA_W-1){1'b0}}, full},  {{(DATA_W-1){1'b0}}, model.size() == DEPTH});
        if (model.size() > 0) check("dout_head", dout, model[0]);
        wr_en = w;
        din   = d;
        rd_en = r;
        wa = w && (model.size() < DEPTH);
        ra = r && (model.size() > 0);
        if (ra) exp_q.push_back(model.pop_front());
        if (wa) model.push_back(d);
        if (model.size() > max_occ) max_occ = model.size();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pw[$];
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        #1;
        check("rst_empty", {{(DATA_W-1){1'b0}}, empty}, {{(DATA_W-1){1'b0}}, 1'b1});
        check("rst_full",  {{(DATA_W-1){1'b0}}, full},  {(DATA_W){1'b0}});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Underflow: reads on an empty FIFO are ignored.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        // Back-to-back writes then pops.
        step(1'b1, 512'd10, 1'b0);
        step(1'b1, 512'd11, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Engine pipeline: pop issued 66 cycles after each write.
        max_occ = 0;
        for (int t = 0; t < 132; t++) begin
            logic w;
            logic r;
            w = (t < 66);
            pw.push_back(w);
            r = (t >= 66) ? pw[t-66] : 1'b0;
            step(w, DATA_W'(t), r);
        end
        check("pipe_max_occ", DATA_W'(max_occ), DATA_W'(66));
        step(1'b0, '0, 1'b0);

        // Fill to full, overflow write, then simultaneous read/write while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0);
        step(1'b1, 512'd999, 1'b0);
        step(1'b1, 512'd777, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Steady state at occupancy 5 across pointer wrap.
        for (int i = 0; i < 5; i++) step(1'b1, rand_word(), 1'b0);
        for (int i = 0; i < 200; i++) step(1'b1, rand_word(), 1'b1);

        // Random mix of reads and writes.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 55), rand_word(), 1'($urandom_range(0, 99) < 45));
        end

        // Reset mid-stream with data held.
        for (int i = 0; i < 4; i++) step(1'b1, rand_word(), 1'b0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_empty", {{(DATA_W-1){1'b0}}, empty}, {{(DATA_W-1){1'b0}}, 1'b1});
        check("midrst_full",  {{(DATA_W-1){1'b0}}, full},  {(DATA_W){1'b0}});
        model.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 512'hA5, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        check("scoreboard_drained", DATA_W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
